// File: rtl/mips_cpu_sequencer.sv
// Multicycle control sequencer for the bus-interfaced MIPS CPU.
// Owns the program counter and the shared memory bus. Each instruction is
// stepped through FETCH, EXEC and (for loads/stores) MEM. The block handles
// the one-instruction branch delay slot and halts when the next PC is zero.
// Decoder register-write and memory-request outputs are gated so that each
// acts exactly once per instruction.
module mips_cpu_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        waitrequest,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [3:0]  byte_enable,
  input  logic        reg_write_enable,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] mem_addr,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic        ir_load,
  output logic        regfile_we,
  output logic [31:0] pc,
  output logic        active
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [31:0] pc_r;
  logic [31:0] pc_nxt_s;
  logic        delay_pending_r;
  logic        delay_pending_nxt_s;
  logic [31:0] delay_target_r;
  logic [31:0] delay_target_nxt_s;
  logic        active_r;
  logic        active_nxt_s;
  logic        retire_s;
  logic [31:0] next_pc_s;

  // Sequential PC increment; wraps modulo 2^32 so 32'hFFFFFFFC steps to 0.
  function automatic logic [31:0] pc_plus4(input logic [31:0] cur);
    return cur + 32'd4;
  endfunction

  assign pc     = pc_r;
  assign active = active_r;

  // Bus outputs, strobes and the retire condition decoded from the current state.
  always_comb begin
    address    = pc_r;
    read       = 1'b0;
    write      = 1'b0;
    byteenable = 4'b0000;
    ir_load    = 1'b0;
    regfile_we = 1'b0;
    retire_s   = 1'b0;
    case (state_r)
      ST_FETCH: begin
        read       = 1'b1;
        byteenable = 4'b1111;
        if (clk_enable && !waitrequest) begin
          ir_load = 1'b1;
        end else begin
          ir_load = 1'b0;
        end
      end
      ST_EXEC: begin
        if (data_read || data_write) begin
          retire_s   = 1'b0;
          regfile_we = 1'b0;
        end else begin
          retire_s   = clk_enable;
          regfile_we = clk_enable & reg_write_enable;
        end
      end
      ST_MEM: begin
        address    = mem_addr;
        read       = data_read;
        write      = data_write;
        byteenable = byte_enable;
        if (!waitrequest) begin
          retire_s   = clk_enable;
          regfile_we = clk_enable & reg_write_enable;
        end else begin
          retire_s   = 1'b0;
          regfile_we = 1'b0;
        end
      end
      ST_HALT: begin
        address = pc_r;
      end
      default: begin
        address = pc_r;
      end
    endcase
  end

  // Delay-slot bookkeeping: the slot instruction retires to the saved target,
  // and a branch inside the slot is deliberately ignored.
  always_comb begin
    next_pc_s           = pc_plus4(pc_r);
    delay_pending_nxt_s = delay_pending_r;
    delay_target_nxt_s  = delay_target_r;
    if (retire_s) begin
      if (delay_pending_r) begin
        next_pc_s           = delay_target_r;
        delay_pending_nxt_s = 1'b0;
      end else if (branch_taken) begin
        delay_target_nxt_s  = branch_target;
        delay_pending_nxt_s = 1'b1;
      end else begin
        next_pc_s = pc_plus4(pc_r);
      end
    end else begin
      next_pc_s = pc_plus4(pc_r);
    end
  end

  // Next-state, PC and halt decision.
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    active_nxt_s = active_r;
    case (state_r)
      ST_FETCH: begin
        if (!waitrequest) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_EXEC, ST_MEM: begin
        if (state_r == ST_EXEC && (data_read || data_write)) begin
          state_nxt_s = ST_MEM;
        end else if (retire_s) begin
          if (next_pc_s == 32'h00000000) begin
            state_nxt_s  = ST_HALT;
            pc_nxt_s     = 32'h00000000;
            active_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_FETCH;
            pc_nxt_s    = next_pc_s;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_HALT;
      end
    endcase
  end

  // State registers: synchronous reset, frozen while clk_enable is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_FETCH;
      pc_r            <= RESET_VECTOR;
      delay_pending_r <= 1'b0;
      delay_target_r  <= 32'h00000000;
      active_r        <= 1'b1;
    end else if (clk_enable) begin
      state_r         <= state_nxt_s;
      pc_r            <= pc_nxt_s;
      delay_pending_r <= delay_pending_nxt_s;
      delay_target_r  <= delay_target_nxt_s;
      active_r        <= active_nxt_s;
    end
  end

endmodule

// File: tb/tb_mips_cpu_sequencer.sv
// Scoreboard bench for mips_cpu_sequencer: a directed instruction table
// drives the decoder/datapath inputs; expected bus events and per-cycle
// probes are queued and checked by a single monitor on the falling edge.
module tb_mips_cpu_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        waitrequest = 1'b0;
  logic        data_read = 1'b0;
  logic        data_write = 1'b0;
  logic [3:0]  byte_enable = 4'b0000;
  logic        reg_write_enable = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic [3:0]  byteenable;
  logic        ir_load;
  logic        regfile_we;
  logic [31:0] pc;
  logic        active;

  mips_cpu_sequencer #(.RESET_VECTOR(32'hBFC00000)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .waitrequest(waitrequest),
    .data_read(data_read), .data_write(data_write), .byte_enable(byte_enable),
    .reg_write_enable(reg_write_enable), .branch_taken(branch_taken),
    .branch_target(branch_target), .mem_addr(mem_addr), .address(address),
    .read(read), .write(write), .byteenable(byteenable), .ir_load(ir_load),
    .regfile_we(regfile_we), .pc(pc), .active(active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    int          fw;
    logic        dr;
    logic        dw;
    logic [3:0]  be;
    logic        rwe;
    logic        bt;
    logic [31:0] tgt;
    logic [31:0] maddr;
    int          mw;
    bit          freeze;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic        irl;
    logic        rwe;
    logic [31:0] pc;
  } exp_t;

  typedef struct {
    string       name;
    bit [7:0]    mask;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  be;
    logic        irl;
    logic        rwe;
    logic [31:0] pc;
    logic        act;
  } probe_t;

  localparam bit [7:0] M_ADDR = 8'h01, M_RD = 8'h02, M_WR = 8'h04, M_BE = 8'h08;
  localparam bit [7:0] M_IRL = 8'h10, M_RWE = 8'h20, M_PC = 8'h40, M_ACT = 8'h80;

  exp_t   sb_q[$];
  probe_t probe_q[$];
  vec_t   vecs[14];
  int     n_checks = 0;
  int     n_errors = 0;
  bit     done = 1'b0;

  task automatic probe(input string n, input bit [7:0] m, input logic [31:0] a,
                       input logic rd, input logic wr, input logic [3:0] be,
                       input logic irl, input logic rwe, input logic [31:0] p,
                       input logic act);
    probe_t q;
    q = '{n, m, a, rd, wr, be, irl, rwe, p, act};
    probe_q.push_back(q);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    e = '{v.pc, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, v.pc};
    sb_q.push_back(e);
    if (v.freeze) begin
      clk_enable  = 1'b0;
      waitrequest = 1'b0;
      for (int i = 0; i < 3; i++) begin
        probe("freeze_fetch", M_ADDR | M_RD | M_IRL | M_PC | M_ACT,
              v.pc, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, v.pc, 1'b1);
        step();
      end
      clk_enable = 1'b1;
    end
    waitrequest = 1'b1;
    for (int i = 0; i < v.fw; i++) begin
      probe("fetch_wait", M_ADDR | M_RD | M_WR | M_BE | M_IRL | M_PC | M_ACT,
            v.pc, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, v.pc, 1'b1);
      step();
    end
    waitrequest = 1'b0;
    step();
    data_read        = v.dr;
    data_write       = v.dw;
    byte_enable      = v.be;
    reg_write_enable = v.rwe;
    branch_taken     = v.bt;
    branch_target    = v.tgt;
    mem_addr         = v.maddr;
    probe("exec_no_bus", M_RD | M_WR | M_IRL | M_PC | M_ACT,
          32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, v.pc, 1'b1);
    if (!(v.dr || v.dw)) begin
      if (v.rwe) begin
        e = '{32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, v.pc};
        sb_q.push_back(e);
      end
      step();
    end else begin
      probe("exec_no_rwe", M_RWE, 32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, v.pc, 1'b1);
      step();
      e = '{v.maddr, v.dr, v.dw, v.be, 1'b0, v.rwe, v.pc};
      sb_q.push_back(e);
      waitrequest = 1'b1;
      for (int i = 0; i < v.mw; i++) begin
        probe("mem_wait", M_ADDR | M_RD | M_WR | M_BE | M_IRL | M_RWE | M_PC,
              v.maddr, v.dr, v.dw, v.be, 1'b0, 1'b0, v.pc, 1'b1);
        step();
      end
      waitrequest = 1'b0;
      step();
    end
    data_read        = 1'b0;
    data_write       = 1'b0;
    byte_enable      = 4'b0000;
    reg_write_enable = 1'b0;
    branch_taken     = 1'b0;
    branch_target    = 32'h0;
    mem_addr         = 32'h0;
  endtask

  task automatic check_halt(input int n);
    for (int i = 0; i < n; i++) begin
      probe("halted", M_RD | M_WR | M_IRL | M_RWE | M_PC | M_ACT,
            32'h0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h00000000, 1'b0);
      step();
    end
  endtask

  // Stimulus: directed instruction table with hand-computed fetch addresses.
  initial begin
    //            pc            fw dr    dw    be       rwe   bt    tgt           maddr         mw freeze
    vecs[0]  = '{32'hBFC00000, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,        32'h0,        0, 1'b0};
    vecs[1]  = '{32'hBFC00004, 3, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0};
    vecs[2]  = '{32'hBFC00008, 0, 1'b1, 1'b0, 4'b0011, 1'b1, 1'b0, 32'h0,        32'h00001002, 2, 1'b0};
    vecs[3]  = '{32'hBFC0000C, 0, 1'b0, 1'b1, 4'b1111, 1'b0, 1'b0, 32'h0,        32'h00002000, 1, 1'b0};
    vecs[4]  = '{32'hBFC00010, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hBFC00100, 32'h0,        0, 1'b0};
    vecs[5]  = '{32'hBFC00014, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b1, 32'hDEAD0000, 32'h0,        0, 1'b0};
    vecs[6]  = '{32'hBFC00100, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hBFC00020, 32'h0,        0, 1'b0};
    vecs[7]  = '{32'hBFC00104, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,        32'h0,        0, 1'b1};
    vecs[8]  = '{32'hBFC00020, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'h00000000, 32'h0,        0, 1'b0};
    vecs[9]  = '{32'hBFC00024, 0, 1'b1, 1'b0, 4'b1111, 1'b1, 1'b0, 32'h0,        32'h00003000, 1, 1'b0};
    vecs[10] = '{32'hBFC00000, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, 32'hFFFFFFF8, 32'h0,        0, 1'b0};
    vecs[11] = '{32'hBFC00004, 0, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0};
    vecs[12] = '{32'hFFFFFFF8, 0, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 32'h0,        32'h0,        0, 1'b0};
    vecs[13] = '{32'hFFFFFFFC, 1, 1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, 32'h0,        32'h0,        0, 1'b0};

    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    probe("reset_state", M_ADDR | M_RD | M_WR | M_BE | M_PC | M_ACT,
          32'hBFC00000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 32'hBFC00000, 1'b1);
    for (int i = 0; i < 10; i++) run_vec(vecs[i]);
    check_halt(4);

    reset = 1'b1;
    step();
    reset = 1'b0;
    probe("reset_restart", M_ADDR | M_RD | M_PC | M_ACT,
          32'hBFC00000, 1'b1, 1'b0, 4'b1111, 1'b0, 1'b0, 32'hBFC00000, 1'b1);
    for (int i = 10; i < 14; i++) run_vec(vecs[i]);
    check_halt(3);
    done = 1'b1;
  end

  // Monitor: pops the scoreboard on every observable bus/strobe event and
  // drains the per-cycle probes; owns all counters and the summary.
  always @(negedge clk) begin
    exp_t   e;
    probe_t q;
    bit     ok;
    if (!reset) begin
      n_checks++;
      if (read && write) begin
        n_errors++;
        $display("FAIL rd_wr_exclusive: got read=%b write=%b, want not both high", read, write);
      end
      if (clk_enable && (ir_load || regfile_we || ((read || write) && !waitrequest))) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_errors++;
          $display("FAIL sb_unexpected: got addr=%h rd=%b wr=%b irl=%b rwe=%b pc=%h, want no event",
                   address, read, write, ir_load, regfile_we, pc);
        end else begin
          e = sb_q.pop_front();
          ok = (ir_load == e.irl) && (regfile_we == e.rwe) && (read == e.rd) &&
               (write == e.wr) && (pc == e.pc) &&
               (!(e.rd || e.wr) || ((address == e.addr) && (byteenable == e.be)));
          if (!ok) begin
            n_errors++;
            $display("FAIL sb_event: got addr=%h rd=%b wr=%b be=%b irl=%b rwe=%b pc=%h, want addr=%h rd=%b wr=%b be=%b irl=%b rwe=%b pc=%h",
                     address, read, write, byteenable, ir_load, regfile_we, pc,
                     e.addr, e.rd, e.wr, e.be, e.irl, e.rwe, e.pc);
          end
        end
      end
    end
    while (probe_q.size() != 0) begin
      q = probe_q.pop_front();
      n_checks++;
      ok = (((q.mask & M_ADDR) == 8'h0) || (address == q.addr)) &&
           (((q.mask & M_RD) == 8'h0) || (read == q.rd)) &&
           (((q.mask & M_WR) == 8'h0) || (write == q.wr)) &&
           (((q.mask & M_BE) == 8'h0) || (byteenable == q.be)) &&
           (((q.mask & M_IRL) == 8'h0) || (ir_load == q.irl)) &&
           (((q.mask & M_RWE) == 8'h0) || (regfile_we == q.rwe)) &&
           (((q.mask & M_PC) == 8'h0) || (pc == q.pc)) &&
           (((q.mask & M_ACT) == 8'h0) || (active == q.act));
      if (!ok) begin
        n_errors++;
        $display("FAIL %s: got addr=%h rd=%b wr=%b be=%b irl=%b rwe=%b pc=%h act=%b, want addr=%h rd=%b wr=%b be=%b irl=%b rwe=%b pc=%h act=%b (mask %h)",
                 q.name, address, read, write, byteenable, ir_load, regfile_we, pc, active,
                 q.addr, q.rd, q.wr, q.be, q.irl, q.rwe, q.pc, q.act, q.mask);
      end
    end
    if (done) begin
      n_checks++;
      if (sb_q.size() != 0) begin
        n_errors++;
        $display("FAIL sb_leftover: got %0d unmatched expected events, want 0", sb_q.size());
      end
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
    end
  end

  // Safety net so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the stimulus");
    $fatal(1, "timeout");
  end

endmodule
